// File: rtl/pcpi_div_multibit.sv
// PCPI divider for RV32M DIV/DIVU/REM/REMU, BITS_PER_CYCLE restoring steps per clock.
// Optional PCPI_DIV_EARLY_EXIT_EN skips the dividend's leading-zero steps.
module pcpi_div_multibit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int unsigned ITER = XLEN / BITS_PER_CYCLE;
  localparam int unsigned CW   = $clog2(ITER + 1);
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_DONE} state_t;

  state_t          state, state_nx;
  logic            op_div, op_div_nx;
  logic            op_signed, op_signed_nx;
  logic            neg_q, neg_q_nx;
  logic            neg_r, neg_r_nx;
  logic            special, special_nx;
  logic [XLEN-1:0] quo, quo_nx;
  logic [XLEN-1:0] dvs, dvs_nx;
  logic [XLEN:0]   rem, rem_nx;
  logic [CW-1:0]   count, count_nx;
  logic            wr_nx, ready_nx, wait_nx;
  logic [XLEN-1:0] rd_nx;

  logic            insn_hit;
  logic [XLEN-1:0] abs1, abs2;
  logic            unused_bits;

  assign insn_hit = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) &&
                    pcpi_insn[14];
  assign abs1 = (op_signed && pcpi_rs1[XLEN-1]) ? XLEN'(-pcpi_rs1) : pcpi_rs1;
  assign abs2 = (op_signed && pcpi_rs2[XLEN-1]) ? XLEN'(-pcpi_rs2) : pcpi_rs2;
  assign unused_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7], rem[XLEN]};

`ifdef PCPI_DIV_EARLY_EXIT_EN
  function automatic int unsigned lzc(input logic [XLEN-1:0] v);
    int unsigned n;
    n = XLEN;
    for (int unsigned i = 0; i < XLEN; i++)
      if (v[i]) n = XLEN - 1 - i;
    return n;
  endfunction
`endif

  // Next-state, datapath and registered-output values
  always_comb begin
    logic [XLEN:0]   r_t;
    logic [XLEN-1:0] q_t;
`ifdef PCPI_DIV_EARLY_EXIT_EN
    int unsigned     ec;
`endif
    state_nx     = state;
    op_div_nx    = op_div;
    op_signed_nx = op_signed;
    neg_q_nx     = neg_q;
    neg_r_nx     = neg_r;
    special_nx   = special;
    quo_nx       = quo;
    dvs_nx       = dvs;
    rem_nx       = rem;
    count_nx     = count;
    wr_nx        = 1'b0;
    ready_nx     = 1'b0;
    wait_nx      = 1'b0;
    rd_nx        = '0;
    r_t          = rem;
    q_t          = quo;
`ifdef PCPI_DIV_EARLY_EXIT_EN
    ec           = (XLEN - lzc(abs1) + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
`endif

    case (state)
      S_IDLE: begin
        if (pcpi_valid && !pcpi_ready && insn_hit) begin
          state_nx     = S_LOAD;
          op_div_nx    = ~pcpi_insn[13];
          op_signed_nx = ~pcpi_insn[12];
          wait_nx      = 1'b1;
        end
      end

      S_LOAD: begin
        if (!pcpi_valid) begin
          state_nx = S_IDLE;
        end else begin
          wait_nx    = 1'b1;
          neg_q_nx   = op_signed & (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]);
          neg_r_nx   = op_signed & pcpi_rs1[XLEN-1];
          dvs_nx     = abs2;
          rem_nx     = '0;
          quo_nx     = abs1;
          count_nx   = CW'(ITER);
          special_nx = 1'b0;
          if (pcpi_rs2 == '0) begin
            special_nx = 1'b1;
            quo_nx     = op_div ? '1 : pcpi_rs1;
            state_nx   = S_DONE;
          end else if (op_signed && pcpi_rs1 == MIN_INT && pcpi_rs2 == '1) begin
            special_nx = 1'b1;
            quo_nx     = op_div ? MIN_INT : '0;
            state_nx   = S_DONE;
`ifdef PCPI_DIV_EARLY_EXIT_EN
          end else if (abs1 == '0) begin
            special_nx = 1'b1;
            quo_nx     = '0;
            state_nx   = S_DONE;
          end else begin
            // Leading zeros would only shift zeros into the remainder, so skip them.
            count_nx = CW'(ec);
            quo_nx   = abs1 << (XLEN - ec * BITS_PER_CYCLE);
            state_nx = S_CALC;
          end
`else
          end else begin
            state_nx = S_CALC;
          end
`endif
        end
      end

      S_CALC: begin
        if (!pcpi_valid) begin
          state_nx = S_IDLE;
        end else begin
          wait_nx = 1'b1;
          // Chained restoring steps, most significant quotient bit first
          for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            r_t = {r_t[XLEN-1:0], q_t[XLEN-1]};
            q_t = {q_t[XLEN-2:0], 1'b0};
            if (r_t >= {1'b0, dvs}) begin
              r_t    = r_t - {1'b0, dvs};
              q_t[0] = 1'b1;
            end
          end
          rem_nx   = r_t;
          quo_nx   = q_t;
          count_nx = count - CW'(1);
          if (count == CW'(1)) state_nx = S_DONE;
        end
      end

      S_DONE: begin
        ready_nx = 1'b1;
        wr_nx    = 1'b1;
        state_nx = S_IDLE;
        if (special)     rd_nx = quo;
        else if (op_div) rd_nx = neg_q ? XLEN'(-quo) : quo;
        else             rd_nx = neg_r ? XLEN'(-rem[XLEN-1:0]) : rem[XLEN-1:0];
      end

      default: state_nx = S_IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      op_div     <= 1'b0;
      op_signed  <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      special    <= 1'b0;
      quo        <= '0;
      dvs        <= '0;
      rem        <= '0;
      count      <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wait  <= 1'b0;
      pcpi_rd    <= '0;
    end else begin
      state      <= state_nx;
      op_div     <= op_div_nx;
      op_signed  <= op_signed_nx;
      neg_q      <= neg_q_nx;
      neg_r      <= neg_r_nx;
      special    <= special_nx;
      quo        <= quo_nx;
      dvs        <= dvs_nx;
      rem        <= rem_nx;
      count      <= count_nx;
      pcpi_wr    <= wr_nx;
      pcpi_ready <= ready_nx;
      pcpi_wait  <= wait_nx;
      pcpi_rd    <= rd_nx;
    end
  end

endmodule
